fir_xifu_offload: RTL and testbench



---
 rtl/fir_xifu_offload.sv | 160 ++++++++++++++++
 tb/tb_fir_xifu_offload.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_xifu_offload.sv
// Core-side XIF issue/commit initiator for the FIR XIFU coprocessor.
// It holds a candidate FIFO, runs the issue/commit FSM, allocates ids and tracks outstanding instructions.
module fir_xifu_offload #(
  parameter int unsigned ID_WIDTH        = 4,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned FIFO_DEPTH      = 2
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic                                     clear_i,
  input  logic                                     cand_valid_i,
  output logic                                     cand_ready_o,
  input  logic [31:0]                              cand_instr_i,
  input  logic [31:0]                              cand_rs1_i,
  input  logic [31:0]                              cand_rs2_i,
  output logic                                     issue_valid_o,
  input  logic                                     issue_ready_i,
  output logic [31:0]                              issue_instr_o,
  output logic [31:0]                              issue_rs0_o,
  output logic [31:0]                              issue_rs1_o,
  output logic [ID_WIDTH-1:0]                      issue_id_o,
  input  logic                                     issue_accept_i,
  input  logic                                     issue_writeback_i,
  input  logic                                     issue_loadstore_i,
  output logic                                     commit_valid_o,
  output logic [ID_WIDTH-1:0]                      commit_id_o,
  output logic                                     commit_kill_o,
  input  logic                                     kill_i,
  input  logic                                     retire_i,
  output logic                                     illegal_o,
  output logic                                     resp_wb_o,
  output logic                                     resp_ls_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ISSUE  = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } cand_t;

  cand_t               mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    fifo_cnt_q;
  logic                fifo_full, fifo_empty;
  logic                push, pop;
  cand_t               head;

  logic [1:0]          state_q, state_d;
  logic [ID_WIDTH-1:0] id_q, commit_id_q;
  logic [OUT_W-1:0]    out_q;
  logic                illegal_q, resp_wb_q, resp_ls_q;
  logic                issue_hs, accept_hs, retire_dec;

  assign fifo_full    = (fifo_cnt_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty   = (fifo_cnt_q == '0);
  assign cand_ready_o = !fifo_full;
  assign push         = cand_valid_i && cand_ready_o;
  assign head         = mem[rd_ptr_q];

  assign issue_hs   = (state_q == ISSUE) && issue_ready_i;
  assign accept_hs  = issue_hs && issue_accept_i;
  assign pop        = issue_hs;
  // A retire with nothing outstanding is dropped so the counter saturates at zero.
  assign retire_dec = retire_i && (out_q != '0);

  // NOTE: the storage array has no reset; a slot is only read after it was written,
  // and the issue outputs are gated by issue_valid_o so stale contents never leak out.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= '{instr: cand_instr_i, rs1: cand_rs1_i, rs2: cand_rs2_i};
  end

  // NOTE: all state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else if (clear_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  always_comb begin
    // NOTE: default assignment first, so no branch leaves state_d unassigned and no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty && (out_q < OUT_W'(MAX_OUTSTANDING))) state_d = ISSUE;
      ISSUE:   if (issue_hs) state_d = issue_accept_i ? COMMIT : IDLE;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      id_q        <= '0;
      commit_id_q <= '0;
      out_q       <= '0;
      illegal_q   <= 1'b0;
      resp_wb_q   <= 1'b0;
      resp_ls_q   <= 1'b0;
    end else if (clear_i) begin
      state_q     <= IDLE;
      id_q        <= '0;
      commit_id_q <= '0;
      out_q       <= '0;
      illegal_q   <= 1'b0;
      resp_wb_q   <= 1'b0;
      resp_ls_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= issue_hs && !issue_accept_i;
      if (accept_hs) begin
        commit_id_q <= id_q;
        id_q        <= id_q + ID_WIDTH'(1);
        resp_wb_q   <= issue_writeback_i;
        resp_ls_q   <= issue_loadstore_i;
      end
      if (accept_hs && !retire_dec)      out_q <= out_q + OUT_W'(1);
      else if (retire_dec && !accept_hs) out_q <= out_q - OUT_W'(1);
    end
  end

  assign issue_valid_o  = (state_q == ISSUE);
  assign issue_instr_o  = issue_valid_o ? head.instr : '0;
  assign issue_rs0_o    = issue_valid_o ? head.rs1   : '0;
  assign issue_rs1_o    = issue_valid_o ? head.rs2   : '0;
  assign issue_id_o     = issue_valid_o ? id_q       : '0;

  assign commit_valid_o = (state_q == COMMIT);
  assign commit_id_o    = commit_valid_o ? commit_id_q : '0;
  assign commit_kill_o  = commit_valid_o && kill_i;

  assign illegal_o      = illegal_q;
  assign resp_wb_o      = resp_wb_q;
  assign resp_ls_o      = resp_ls_q;
  assign outstanding_o  = out_q;

endmodule

// File: tb/tb_fir_xifu_offload.sv
// Scoreboard bench for fir_xifu_offload: directed scenarios followed by randomized traffic.
// A negedge monitor checks every output against a transaction-level model of the XIF protocol.
module tb_fir_xifu_offload;

  localparam int ID_WIDTH = 4;
  localparam int MAX_OUT  = 4;
  localparam int DEPTH    = 2;
  localparam int OUT_W    = $clog2(MAX_OUT + 1);

  logic                clk_i = 1'b0;
  logic                rst_ni = 1'b0;
  logic                clear_i = 1'b0;
  logic                cand_valid_i = 1'b0;
  logic                cand_ready_o;
  logic [31:0]         cand_instr_i = '0, cand_rs1_i = '0, cand_rs2_i = '0;
  logic                issue_valid_o;
  logic                issue_ready_i = 1'b0;
  logic [31:0]         issue_instr_o, issue_rs0_o, issue_rs1_o;
  logic [ID_WIDTH-1:0] issue_id_o;
  logic                issue_accept_i = 1'b0, issue_writeback_i = 1'b0, issue_loadstore_i = 1'b0;
  logic                commit_valid_o;
  logic [ID_WIDTH-1:0] commit_id_o;
  logic                commit_kill_o;
  logic                kill_i = 1'b0, retire_i = 1'b0;
  logic                illegal_o, resp_wb_o, resp_ls_o;
  logic [OUT_W-1:0]    outstanding_o;

  fir_xifu_offload #(.ID_WIDTH(ID_WIDTH), .MAX_OUTSTANDING(MAX_OUT), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .cand_valid_i(cand_valid_i), .cand_ready_o(cand_ready_o),
    .cand_instr_i(cand_instr_i), .cand_rs1_i(cand_rs1_i), .cand_rs2_i(cand_rs2_i),
    .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
    .issue_instr_o(issue_instr_o), .issue_rs0_o(issue_rs0_o), .issue_rs1_o(issue_rs1_o),
    .issue_id_o(issue_id_o), .issue_accept_i(issue_accept_i),
    .issue_writeback_i(issue_writeback_i), .issue_loadstore_i(issue_loadstore_i),
    .commit_valid_o(commit_valid_o), .commit_id_o(commit_id_o), .commit_kill_o(commit_kill_o),
    .kill_i(kill_i), .retire_i(retire_i), .illegal_o(illegal_o),
    .resp_wb_o(resp_wb_o), .resp_ls_o(resp_ls_o), .outstanding_o(outstanding_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: candidate queue in program order, next id, outstanding count.
  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } cand_t;

  cand_t               exp_q[$];
  int                  m_out;
  logic [ID_WIDTH-1:0] m_id, pend_id;
  bit                  pend_commit, pend_illegal, m_wb, m_ls, exp_valid, after_clear;

  task model_reset();
    exp_q.delete();
    m_out        = 0;
    m_id         = '0;
    pend_id      = '0;
    pend_commit  = 0;
    pend_illegal = 0;
    m_wb         = 0;
    m_ls         = 0;
    exp_valid    = 0;
    after_clear  = 1;
  endtask

  always @(negedge clk_i) begin : monitor
    bit hs, acc, dec;
    if (!rst_ni) begin
      model_reset();
    end else begin
      if (after_clear) begin
        check("clr_instr", issue_instr_o, 0);
        check("clr_rs0", issue_rs0_o, 0);
        check("clr_rs1", issue_rs1_o, 0);
        check("clr_id", issue_id_o, 0);
        check("clr_commit_id", commit_id_o, 0);
        check("clr_kill", commit_kill_o, 0);
        after_clear = 0;
      end
      check("outstanding", outstanding_o, m_out);
      check("resp_wb", resp_wb_o, m_wb);
      check("resp_ls", resp_ls_o, m_ls);
      check("cand_ready", cand_ready_o, exp_q.size() < DEPTH);
      check("commit_valid", commit_valid_o, pend_commit);
      if (pend_commit) begin
        check("commit_id", commit_id_o, pend_id);
        check("commit_kill", commit_kill_o, kill_i);
      end
      check("illegal", illegal_o, pend_illegal);
      check("issue_valid", issue_valid_o, exp_valid);
      if (issue_valid_o) begin
        check("issue_fifo_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          check("issue_instr", issue_instr_o, exp_q[0].instr);
          check("issue_rs0", issue_rs0_o, exp_q[0].rs1);
          check("issue_rs1", issue_rs1_o, exp_q[0].rs2);
        end
        check("issue_id", issue_id_o, m_id);
      end

      if (clear_i) begin
        model_reset();
      end else begin
        hs  = issue_valid_o && issue_ready_i;
        acc = hs && issue_accept_i;
        dec = retire_i && (m_out > 0);
        // Idle: issue next cycle if work is queued and the window is open.
        // Requesting: hold until handshake. Anything else returns to idle.
        if (!issue_valid_o && !commit_valid_o) exp_valid = (exp_q.size() != 0) && (m_out < MAX_OUT);
        else exp_valid = issue_valid_o && !hs;
        pend_commit  = acc;
        pend_illegal = hs && !issue_accept_i;
        pend_id      = m_id;
        if (hs && exp_q.size() != 0) void'(exp_q.pop_front());
        if (acc) begin
          m_id++;
          m_wb = issue_writeback_i;
          m_ls = issue_loadstore_i;
        end
        m_out = m_out + (acc ? 1 : 0) - (dec ? 1 : 0);
        if (cand_valid_i && cand_ready_o)
          exp_q.push_back('{instr: cand_instr_i, rs1: cand_rs1_i, rs2: cand_rs2_i});
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_cand(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2);
    int n = 0;
    bit ok = 0;
    cand_instr_i = instr;
    cand_rs1_i   = rs1;
    cand_rs2_i   = rs2;
    cand_valid_i = 1'b1;
    while (!ok && n < 50) begin
      ok = cand_ready_o;
      tick();
      n++;
    end
    cand_valid_i = 1'b0;
    check("push_accepted", ok, 1);
  endtask

  task automatic wait_issue();
    int n = 0;
    while (!issue_valid_o && n < 30) begin tick(); n++; end
    check("wait_issue_timeout", issue_valid_o, 1);
  endtask

  task automatic wait_commit();
    int n = 0;
    while (!commit_valid_o && n < 30) begin tick(); n++; end
    check("wait_commit_timeout", commit_valid_o, 1);
  endtask

  task automatic pulse_clear();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    rst_ni = 1'b1;
    tick();

    // Single accepted candidate: issue one cycle after the push lands, commit the cycle after.
    issue_ready_i = 1'b1; issue_accept_i = 1'b1; issue_writeback_i = 1'b1; issue_loadstore_i = 1'b0;
    push_cand(32'h0000_2A0B, 32'h100, 32'h7);
    check("d1_not_yet", issue_valid_o, 0);
    tick();
    check("d1_valid", issue_valid_o, 1);
    check("d1_id", issue_id_o, 0);
    check("d1_rs0", issue_rs0_o, 32'h100);
    check("d1_instr", issue_instr_o, 32'h0000_2A0B);
    tick();
    check("d1_commit", commit_valid_o, 1);
    check("d1_commit_id", commit_id_o, 0);
    check("d1_kill", commit_kill_o, 0);
    check("d1_out", outstanding_o, 1);
    check("d1_wb", resp_wb_o, 1);
    retire_i = 1'b1;
    tick();
    retire_i = 1'b0;
    check("d1_retired", outstanding_o, 0);

    // Coprocessor not ready: request must hold for three cycles, handshake on the fourth.
    issue_ready_i = 1'b0;
    push_cand(32'h00A0_0B0B, 32'hDEAD, 32'hBEEF);
    wait_issue();
    for (int i = 0; i < 3; i++) begin
      check("d2_hold_valid", issue_valid_o, 1);
      check("d2_hold_instr", issue_instr_o, 32'h00A0_0B0B);
      check("d2_hold_rs1", issue_rs1_o, 32'hBEEF);
      check("d2_hold_id", issue_id_o, 1);
      tick();
    end
    issue_ready_i = 1'b1;
    tick();
    check("d2_commit_id", commit_id_o, 1);
    retire_i = 1'b1;
    tick();
    retire_i = 1'b0;

    // Rejection: illegal pulse, no commit, id not consumed.
    pulse_clear();
    issue_accept_i = 1'b0;
    push_cand(32'h0000_000B, 32'h1, 32'h2);
    wait_issue();
    tick();
    check("d3_illegal", illegal_o, 1);
    check("d3_no_commit", commit_valid_o, 0);
    tick();
    check("d3_illegal_once", illegal_o, 0);
    issue_accept_i = 1'b1;
    push_cand(32'h0000_010B, 32'h3, 32'h4);
    wait_issue();
    check("d3_id_reused", issue_id_o, 0);
    tick();
    check("d3_commit_id", commit_id_o, 0);

    // Outstanding limit: four issue, the rest wait in a full FIFO until a retire.
    pulse_clear();
    for (int i = 0; i < 6; i++) push_cand(32'h1000 + i, 32'h20 + i, 32'h40 + i);
    repeat (12) tick();
    check("d4_out_max", outstanding_o, MAX_OUT);
    check("d4_full", cand_ready_o, 0);
    check("d4_stalled", issue_valid_o, 0);
    retire_i = 1'b1;
    tick();
    retire_i = 1'b0;
    wait_issue();
    check("d4_fifth_id", issue_id_o, 4);
    check("d4_fifth_instr", issue_instr_o, 32'h1004);
    retire_i = 1'b1;
    repeat (12) tick();
    retire_i = 1'b0;
    check("d4_drained", outstanding_o, 0);

    // Kill during commit: flagged on the commit, counter waits for the retire.
    kill_i = 1'b1;
    push_cand(32'h0000_500B, 32'h5, 32'h6);
    wait_commit();
    check("d5_kill", commit_kill_o, 1);
    check("d5_out", outstanding_o, 1);
    tick();
    kill_i = 1'b0;
    check("d5_out_held", outstanding_o, 1);
    retire_i = 1'b1;
    tick();
    retire_i = 1'b0;
    check("d5_out_retired", outstanding_o, 0);

    // Accept and retire on the same edge at outstanding 2.
    pulse_clear();
    push_cand(32'h0000_600B, 32'h1, 32'h1);
    push_cand(32'h0000_610B, 32'h2, 32'h2);
    repeat (8) tick();
    check("d6_out2", outstanding_o, 2);
    issue_ready_i = 1'b0;
    push_cand(32'h0000_620B, 32'h3, 32'h3);
    wait_issue();
    retire_i = 1'b1;
    issue_ready_i = 1'b1;
    tick();
    retire_i = 1'b0;
    check("d6_out_same", outstanding_o, 2);
    check("d6_commit_id", commit_id_o, 2);

    // Asynchronous reset while a request is pending.
    issue_ready_i = 1'b0;
    push_cand(32'h0000_700B, 32'h7, 32'h7);
    wait_issue();
    #2 rst_ni = 1'b0;
    #1;
    check("d7_valid", issue_valid_o, 0);
    check("d7_instr", issue_instr_o, 0);
    check("d7_out", outstanding_o, 0);
    check("d7_commit", commit_valid_o, 0);
    check("d7_wb", resp_wb_o, 0);
    check("d7_fifo_empty", cand_ready_o, 1);
    tick();
    rst_ni = 1'b1;
    tick();

    // Randomized traffic; the monitor carries all checking here.
    for (int c = 0; c < 800; c++) begin
      issue_ready_i     = ($urandom_range(0, 3) != 0);
      issue_accept_i    = ($urandom_range(0, 4) != 0);
      issue_writeback_i = $urandom_range(0, 1);
      issue_loadstore_i = $urandom_range(0, 1);
      retire_i          = ($urandom_range(0, 3) == 0);
      kill_i            = ($urandom_range(0, 2) == 0);
      clear_i           = ($urandom_range(0, 99) < 2);
      cand_valid_i      = $urandom_range(0, 1);
      cand_instr_i      = $urandom;
      cand_rs1_i        = $urandom;
      cand_rs2_i        = $urandom;
      tick();
    end

    cand_valid_i = 1'b0; clear_i = 1'b0; kill_i = 1'b0;
    issue_ready_i = 1'b1; issue_accept_i = 1'b1; retire_i = 1'b1;
    repeat (30) tick();
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_out_zero", outstanding_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
